// File: rtl/link_pkg.sv
// link_pkg: link state encodings, failure cause codes and timer width shared by the link monitors
package link_pkg;
    localparam int TIMER_W = 24;
    typedef enum logic [1:0] {
        LS_DOWN = 2'd0,
        LS_QUAL = 2'd1,
        LS_UP   = 2'd2,
        LS_FAIL = 2'd3
    } link_state_e;
    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_LOSS = 2'd1,
        FC_ACT  = 2'd2,
        FC_ERR  = 2'd3
    } fail_cause_e;
endpackage

// File: rtl/link_monitor_bit_sync_2ff.sv
// bit_sync_2ff: two-flop synchroniser bringing an asynchronous level into the clk domain
module bit_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    // shift the raw level through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/link_monitor.sv
// link_monitor: qualifies a raw PHY link into a debounced link_ok with failure detection and hold-down
module link_monitor #(
    parameter int unsigned QUAL_CYCLES = 1_000_000,
    parameter int unsigned ACT_TIMEOUT = 4_000_000,
    parameter int unsigned ERR_WINDOW  = 65_536,
    parameter int unsigned ERR_THRESH  = 8,
    parameter int unsigned HOLD_CYCLES = 4_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phy_link,
    input  logic       rx_activity,
    input  logic       rx_error,
    output logic       link_ok,
    output logic [1:0] link_state,
    output logic [1:0] fail_cause,
    output logic [7:0] flap_count
);
    import link_pkg::*;
    localparam logic [TIMER_W-1:0] QUAL_LAST = TIMER_W'(QUAL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ACT_LAST  = TIMER_W'(ACT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(ERR_WINDOW - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]         ERR_LAST  = 8'(ERR_THRESH - 1);

    link_state_e        state_q, state_d;
    fail_cause_e        cause_q, cause_d;
    logic [TIMER_W-1:0] timer_q, timer_d, act_q, act_d, win_q, win_d;
    logic [7:0]         err_cnt_q, err_cnt_d, flap_q, flap_d;
    logic               link_ok_q, link_ok_d;
    logic               link_s, win_wrap, stay, in_up;
    logic [7:0]         err_prev;

    bit_sync_2ff #(.RST_VAL(1'b0)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (phy_link),
        .q     (link_s)
    );

    // next state, failure cause, shared timer and UP-only activity/error counters
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        win_wrap = win_q == WIN_LAST;
        err_prev = win_wrap ? 8'd0 : err_cnt_q;
        unique case (state_q)
            LS_DOWN: if (link_s) state_d = LS_QUAL;
            LS_QUAL: if (!link_s) state_d = LS_DOWN;
                     else if (timer_q == QUAL_LAST) state_d = LS_UP;
            LS_UP: begin
                if (!link_s) begin
                    state_d = LS_FAIL;
                    cause_d = FC_LOSS;
                end else if (act_q == ACT_LAST && !rx_activity) begin
                    state_d = LS_FAIL;
                    cause_d = FC_ACT;
                end else if (rx_error && err_prev == ERR_LAST) begin
                    state_d = LS_FAIL;
                    cause_d = FC_ERR;
                end
            end
            LS_FAIL: if (timer_q == HOLD_LAST) state_d = LS_DOWN;
        endcase
        stay      = state_d == state_q;
        in_up     = stay && state_q == LS_UP;
        timer_d   = (stay && (state_q == LS_QUAL || state_q == LS_FAIL)) ? timer_q + 1'b1 : '0;
        act_d     = (in_up && !rx_activity) ? act_q + 1'b1 : '0;
        win_d     = (in_up && !win_wrap) ? win_q + 1'b1 : '0;
        err_cnt_d = in_up ? err_prev + {7'd0, rx_error} : 8'd0;
        flap_d    = (state_q == LS_UP && state_d == LS_FAIL && flap_q != 8'hFF) ? flap_q + 1'b1 : flap_q;
        link_ok_d = state_d == LS_UP;
    end

    // register state, counters and outputs; reset aborts everything back to DOWN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LS_DOWN;
            cause_q   <= FC_NONE;
            timer_q   <= '0;
            act_q     <= '0;
            win_q     <= '0;
            err_cnt_q <= '0;
            flap_q    <= '0;
            link_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            timer_q   <= timer_d;
            act_q     <= act_d;
            win_q     <= win_d;
            err_cnt_q <= err_cnt_d;
            flap_q    <= flap_d;
            link_ok_q <= link_ok_d;
        end
    end

    assign link_ok    = link_ok_q;
    assign link_state = state_q;
    assign fail_cause = cause_q;
    assign flap_count = flap_q;
endmodule

// File: tb/tb_link_monitor.sv
// tb_link_monitor: directed bench for link_monitor with small timing parameters
module tb_link_monitor;
    logic       clk = 1'b0;
    logic       rst_n, phy_link, rx_activity, rx_error;
    logic       link_ok;
    logic [1:0] link_state, fail_cause;
    logic [7:0] flap_count;
    int         vectors = 0;
    int         errors = 0;
    logic       act_en;
    int         phase;

    link_monitor #(
        .QUAL_CYCLES (10),
        .ACT_TIMEOUT (20),
        .ERR_WINDOW  (16),
        .ERR_THRESH  (3),
        .HOLD_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phy_link    (phy_link),
        .rx_activity (rx_activity),
        .rx_error    (rx_error),
        .link_ok     (link_ok),
        .link_state  (link_state),
        .fail_cause  (fail_cause),
        .flap_count  (flap_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        rx_error = 1'b0;
        if (act_en) begin
            phase = (phase + 1) % 5;
            rx_activity = (phase == 0);
        end else begin
            rx_activity = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int bound, input string tag);
        for (int n = 0; n < bound && link_state !== s; n++) tick();
        chk(tag, {6'd0, link_state}, {6'd0, s});
    endtask

    // called right after the FAIL-entry edge with phy_link held high
    task automatic recover(input string tag);
        ticks(7);
        chk({tag, "_hold"}, {6'd0, link_state}, 8'd3);
        tick();
        chk({tag, "_down"}, {6'd0, link_state}, 8'd0);
        tick();
        chk({tag, "_qual"}, {6'd0, link_state}, 8'd1);
        ticks(9);
        chk({tag, "_qual_end"}, {6'd0, link_state}, 8'd1);
        tick();
        chk({tag, "_up"}, {6'd0, link_state}, 8'd2);
    endtask

    initial begin
        rst_n = 1'b0; phy_link = 1'b0; rx_activity = 1'b0; rx_error = 1'b0;
        act_en = 1'b1; phase = 0;
        ticks(2);
        chk("rst_link_ok", {7'd0, link_ok}, 8'd0);
        chk("rst_state", {6'd0, link_state}, 8'd0);
        chk("rst_cause", {6'd0, fail_cause}, 8'd0);
        chk("rst_flap", flap_count, 8'd0);
        rst_n = 1'b1;
        tick();
        // clean bring-up: phy_link first sampled high at edge 0
        phy_link = 1'b1;
        tick();
        tick();
        chk("up_e1_state", {6'd0, link_state}, 8'd0);
        tick();
        chk("up_e2_state", {6'd0, link_state}, 8'd1);
        ticks(9);
        chk("up_e11_ok", {7'd0, link_ok}, 8'd0);
        tick();
        chk("up_e12_ok", {7'd0, link_ok}, 8'd1);
        chk("up_e12_state", {6'd0, link_state}, 8'd2);
        chk("up_cause", {6'd0, fail_cause}, 8'd0);
        chk("up_flap", flap_count, 8'd0);
        // raw loss sampled at edge j
        phy_link = 1'b0;
        tick();
        chk("loss_j_state", {6'd0, link_state}, 8'd2);
        tick();
        chk("loss_j1_ok", {7'd0, link_ok}, 8'd1);
        tick();
        chk("loss_j2_ok", {7'd0, link_ok}, 8'd0);
        chk("loss_j2_state", {6'd0, link_state}, 8'd3);
        chk("loss_cause", {6'd0, fail_cause}, 8'd1);
        chk("loss_flap", flap_count, 8'd1);
        phy_link = 1'b1;
        ticks(4);
        chk("loss_ignore", {6'd0, link_state}, 8'd3);
        phy_link = 1'b0;
        ticks(3);
        chk("loss_j9_state", {6'd0, link_state}, 8'd3);
        tick();
        chk("loss_j10_state", {6'd0, link_state}, 8'd0);
        tick();
        chk("loss_j11_state", {6'd0, link_state}, 8'd0);
        // glitch in QUAL at timer 6, phy_link sampled high again at k+10
        phy_link = 1'b1;
        tick();
        ticks(2);
        chk("gl_qual", {6'd0, link_state}, 8'd1);
        ticks(6);
        phy_link = 1'b0;
        tick();
        phy_link = 1'b1;
        tick();
        tick();
        chk("gl_down", {6'd0, link_state}, 8'd0);
        tick();
        chk("gl_requal", {6'd0, link_state}, 8'd1);
        ticks(9);
        chk("gl_ok_low", {7'd0, link_ok}, 8'd0);
        tick();
        chk("gl_ok_high", {7'd0, link_ok}, 8'd1);
        chk("gl_cause_held", {6'd0, fail_cause}, 8'd1);
        chk("gl_flap", flap_count, 8'd1);
        // activity timeout: last pulse at edge p, FAIL at p+20
        act_en = 1'b0;
        rx_activity = 1'b1;
        tick();
        ticks(19);
        chk("act_p19", {6'd0, link_state}, 8'd2);
        tick();
        chk("act_p20", {6'd0, link_state}, 8'd3);
        chk("act_cause", {6'd0, fail_cause}, 8'd2);
        chk("act_flap", flap_count, 8'd2);
        recover("act_rec");
        // a pulse on exactly the timeout cycle keeps UP
        ticks(19);
        rx_activity = 1'b1;
        tick();
        chk("act_save", {6'd0, link_state}, 8'd2);
        ticks(19);
        chk("act_save_39", {6'd0, link_state}, 8'd2);
        tick();
        chk("act_save_40", {6'd0, link_state}, 8'd3);
        chk("act_flap2", flap_count, 8'd3);
        recover("act_rec2");
        act_en = 1'b1;
        phase = 0;
        // error burst: three errors within one window
        tick();
        rx_error = 1'b1;
        tick();
        tick();
        rx_error = 1'b1;
        tick();
        chk("err_two", {6'd0, link_state}, 8'd2);
        tick();
        rx_error = 1'b1;
        tick();
        chk("err_fail", {6'd0, link_state}, 8'd3);
        chk("err_cause", {6'd0, fail_cause}, 8'd3);
        chk("err_flap", flap_count, 8'd4);
        recover("err_rec");
        // two errors before the wrap, one on the wrap edge
        ticks(9);
        rx_error = 1'b1;
        tick();
        tick();
        rx_error = 1'b1;
        tick();
        ticks(3);
        rx_error = 1'b1;
        tick();
        chk("wrap_state", {6'd0, link_state}, 8'd2);
        chk("wrap_err_cnt", dut.err_cnt_q, 8'd1);
        tick();
        rx_error = 1'b1;
        tick();
        chk("wrap_second", {6'd0, link_state}, 8'd2);
        tick();
        rx_error = 1'b1;
        tick();
        chk("wrap_third", {6'd0, link_state}, 8'd3);
        chk("wrap_flap", flap_count, 8'd5);
        // reset during FAIL
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ok", {7'd0, link_ok}, 8'd0);
        chk("mid_rst_state", {6'd0, link_state}, 8'd0);
        chk("mid_rst_cause", {6'd0, fail_cause}, 8'd0);
        chk("mid_rst_flap", flap_count, 8'd0);
        rst_n = 1'b1;
        // saturation through repeated raw-loss flaps
        phy_link = 1'b1;
        for (int i = 0; i < 260; i++) begin
            wait_state(2'd2, 40, "sat_up");
            phy_link = 1'b0;
            wait_state(2'd3, 10, "sat_fail");
            phy_link = 1'b1;
            if (i == 199) chk("sat_200", flap_count, 8'd200);
        end
        chk("sat_255", flap_count, 8'd255);
        chk("sat_cause", {6'd0, fail_cause}, 8'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
